// File: rtl/proc_pkg.sv
// Shared types for the hazard scoreboard: one tracking entry per post-decode stage.
// Used by hazard_scoreboard and sb_match (FORWARDING_EN is consumed in sb_match).
package proc_pkg;

  localparam int SB_MAX_STAGES = 8;
  localparam int SB_MAX_REG_W  = 8;

  typedef struct packed {
    logic                    valid;
    logic [SB_MAX_REG_W-1:0] rd;
    logic                    wr;
    logic                    is_load;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Per-source RAW check: youngest matching stage wins; flags a hazard when the value cannot be bypassed.
// FORWARDING_EN enables bypassing; without it every match is a hazard and sel stays 0.
module sb_match
  import proc_pkg::*;
#(
  parameter int DEPTH           = 3,
  parameter int REG_ADDR_W      = 5,
  parameter int LOAD_DATA_STAGE = 1,
  parameter int SEL_W           = 2
) (
  input  logic [DEPTH*$bits(sb_entry_t)-1:0] entries,
  input  logic [REG_ADDR_W-1:0]              rs,
  input  logic                               used,
  output logic [SEL_W-1:0]                   sel,
  output logic                               hazard
);

`ifdef FORWARDING_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  sb_entry_t [DEPTH-1:0] ent;
  logic      [DEPTH-1:0] match;

  assign ent = entries;

  always_comb begin
    match = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match[k] = used && ent[k].valid && ent[k].wr && (ent[k].rd == SB_MAX_REG_W'(rs));
    end
  end

  // Scan oldest to youngest so the lowest matching stage overrides.
  always_comb begin
    sel    = '0;
    hazard = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match[k]) begin
        sel    = BYPASS ? SEL_W'(k + 1) : '0;
        hazard = !BYPASS || (ent[k].is_load && (k < LOAD_DATA_STAGE));
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW-hazard scoreboard beside decode: tracks in-flight destinations, selects X-stage bypass sources
// and stalls decode on unbypassable hazards. Define FORWARDING_EN to enable bypassing.
module hazard_scoreboard
  import proc_pkg::*;
#(
  parameter int NUM_STAGES      = 3,
  parameter int REG_ADDR_W      = 5,
  parameter int LOAD_DATA_STAGE = 1,
  parameter int CNT_W           = 16,
  parameter int SEL_W           = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  d_valid_i,
  input  logic [REG_ADDR_W-1:0] d_rs1_addr_i,
  input  logic                  d_rs1_used_i,
  input  logic [REG_ADDR_W-1:0] d_rs2_addr_i,
  input  logic                  d_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] d_rd_addr_i,
  input  logic                  d_rd_wr_i,
  input  logic                  d_is_load_i,
  input  logic                  branch_taken_i,
  output logic                  stall_o,
  output logic                  incr_pc_o,
  output logic                  x_valid_o,
  output logic [SEL_W-1:0]      x_fwd1_sel_o,
  output logic [SEL_W-1:0]      x_fwd2_sel_o,
  output logic                  w_wr_en_o,
  output logic [REG_ADDR_W-1:0] w_rd_addr_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam int DEPTH = (NUM_STAGES > SB_MAX_STAGES) ? SB_MAX_STAGES : NUM_STAGES;

  sb_entry_t [DEPTH-1:0] stage_q;
  sb_entry_t             d_entry;
  logic [SEL_W-1:0]      sel1, sel2, fwd1_q, fwd2_q;
  logic                  haz1, haz2, advance;
  logic [CNT_W-1:0]      cnt_q;

  // x0 is never tracked as a destination, so it can never raise a match.
  always_comb begin
    d_entry         = '0;
    d_entry.valid   = 1'b1;
    d_entry.rd      = SB_MAX_REG_W'(d_rd_addr_i);
    d_entry.wr      = d_rd_wr_i && (d_rd_addr_i != '0);
    d_entry.is_load = d_is_load_i;
  end

  sb_match #(
    .DEPTH(DEPTH), .REG_ADDR_W(REG_ADDR_W), .LOAD_DATA_STAGE(LOAD_DATA_STAGE), .SEL_W(SEL_W)
  ) u_match1 (
    .entries(stage_q), .rs(d_rs1_addr_i), .used(d_rs1_used_i), .sel(sel1), .hazard(haz1)
  );

  sb_match #(
    .DEPTH(DEPTH), .REG_ADDR_W(REG_ADDR_W), .LOAD_DATA_STAGE(LOAD_DATA_STAGE), .SEL_W(SEL_W)
  ) u_match2 (
    .entries(stage_q), .rs(d_rs2_addr_i), .used(d_rs2_used_i), .sel(sel2), .hazard(haz2)
  );

  assign stall_o   = d_valid_i && !branch_taken_i && (haz1 || haz2);
  assign incr_pc_o = !stall_o;
  assign advance   = d_valid_i && !stall_o && !branch_taken_i;

  // The pipe always shifts; a stalled or killed decode slot becomes a bubble.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stage_q <= '0;
      fwd1_q  <= '0;
      fwd2_q  <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q[0] <= advance ? d_entry : '0;
      for (int k = 1; k < DEPTH; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
      fwd1_q <= advance ? sel1 : '0;
      fwd2_q <= advance ? sel2 : '0;
      if (stall_o && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign x_valid_o    = stage_q[0].valid;
  assign x_fwd1_sel_o = fwd1_q;
  assign x_fwd2_sel_o = fwd2_q;
  assign w_wr_en_o    = stage_q[DEPTH-1].valid && stage_q[DEPTH-1].wr;
  assign w_rd_addr_o  = w_wr_en_o ? REG_ADDR_W'(stage_q[DEPTH-1].rd) : '0;
  assign stall_cnt_o  = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard; expectations adapt to whether FORWARDING_EN is defined.
module tb_hazard_scoreboard;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       d_valid_i, d_rs1_used_i, d_rs2_used_i, d_rd_wr_i, d_is_load_i, branch_taken_i;
  logic [4:0] d_rs1_addr_i, d_rs2_addr_i, d_rd_addr_i;
  logic       stall_o, incr_pc_o, x_valid_o, w_wr_en_o;
  logic [1:0] x_fwd1_sel_o, x_fwd2_sel_o;
  logic [4:0] w_rd_addr_o;
  logic [7:0] stall_cnt_o;

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;

  typedef struct {
    string      name;
    logic [1:0] s1;
    logic [1:0] s2;
  } x_exp_t;

  x_exp_t exp_q[$];
  x_exp_t mon_e;

  hazard_scoreboard #(
    .NUM_STAGES(3), .REG_ADDR_W(5), .LOAD_DATA_STAGE(1), .CNT_W(8)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_valid_i(d_valid_i),
    .d_rs1_addr_i(d_rs1_addr_i), .d_rs1_used_i(d_rs1_used_i),
    .d_rs2_addr_i(d_rs2_addr_i), .d_rs2_used_i(d_rs2_used_i),
    .d_rd_addr_i(d_rd_addr_i), .d_rd_wr_i(d_rd_wr_i), .d_is_load_i(d_is_load_i),
    .branch_taken_i(branch_taken_i), .stall_o(stall_o), .incr_pc_o(incr_pc_o),
    .x_valid_o(x_valid_o), .x_fwd1_sel_o(x_fwd1_sel_o), .x_fwd2_sel_o(x_fwd2_sel_o),
    .w_wr_en_o(w_wr_en_o), .w_rd_addr_o(w_rd_addr_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_stall"},    32'(stall_o),      32'd0);
    check_output({tag, "_incr_pc"},  32'(incr_pc_o),    32'd1);
    check_output({tag, "_x_valid"},  32'(x_valid_o),    32'd0);
    check_output({tag, "_fwd1"},     32'(x_fwd1_sel_o), 32'd0);
    check_output({tag, "_fwd2"},     32'(x_fwd2_sel_o), 32'd0);
    check_output({tag, "_w_wr_en"},  32'(w_wr_en_o),    32'd0);
    check_output({tag, "_w_rd"},     32'(w_rd_addr_o),  32'd0);
    check_output({tag, "_cnt"},      32'(stall_cnt_o),  32'd0);
  endtask

  // Holds one decode instruction until accepted; expects exactly exp_stalls stalled cycles first.
  task automatic apply_stimulus(input string name,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic wr, input logic ld,
                                input logic br, input int exp_stalls,
                                input logic [1:0] s1, input logic [1:0] s2);
    x_exp_t e;
    d_valid_i = 1'b1;
    d_rs1_addr_i = rs1; d_rs1_used_i = u1;
    d_rs2_addr_i = rs2; d_rs2_used_i = u2;
    d_rd_addr_i = rd; d_rd_wr_i = wr; d_is_load_i = ld;
    branch_taken_i = br;
    for (int i = 0; i <= exp_stalls; i++) begin
      @(negedge clk_i);
      check_output({name, "_stall"},   32'(stall_o),   32'(i < exp_stalls));
      check_output({name, "_incr_pc"}, 32'(incr_pc_o), 32'(i >= exp_stalls));
      if (i < exp_stalls && exp_cnt != 255) exp_cnt++;
      @(posedge clk_i);
      #1;
    end
    if (!br) begin
      e.name = name;
      e.s1 = FWD ? s1 : 2'd0;
      e.s2 = FWD ? s2 : 2'd0;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    d_valid_i = 1'b0; branch_taken_i = 1'b0;
    d_rs1_used_i = 1'b0; d_rs2_used_i = 1'b0; d_rd_wr_i = 1'b0; d_is_load_i = 1'b0;
    repeat (n) begin
      @(negedge clk_i);
      check_output("idle_stall", 32'(stall_o), 32'd0);
      @(posedge clk_i);
      #1;
    end
  endtask

  // Monitor: every real instruction appearing in X is matched against the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_n_i === 1'b1 && x_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL x_unexpected: got x_valid 1, expected no instruction in X");
      end else begin
        mon_e = exp_q.pop_front();
        check_output({mon_e.name, "_fwd1"}, 32'(x_fwd1_sel_o), 32'(mon_e.s1));
        check_output({mon_e.name, "_fwd2"}, 32'(x_fwd2_sel_o), 32'(mon_e.s2));
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL timeout: got no completion, expected end of stimulus");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n_i = 1'b0;
    d_valid_i = 1'b0; branch_taken_i = 1'b0;
    d_rs1_addr_i = '0; d_rs1_used_i = 1'b0; d_rs2_addr_i = '0; d_rs2_used_i = 1'b0;
    d_rd_addr_i = '0; d_rd_wr_i = 1'b0; d_is_load_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_state("reset");
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_reset_state("post_reset");

    // Back-to-back ALU dependency.
    apply_stimulus("t1_add_x5", 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0);
    apply_stimulus("t1_add_x6", 5, 1, 5, 1, 6, 1, 0, 0, FWD ? 1 - 1 : 3, 1, 1);
    idle(3);

    // Load-use.
    apply_stimulus("t2_lw_x7", 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0);
    apply_stimulus("t2_add_x8", 7, 1, 0, 1, 8, 1, 0, 0, FWD ? 1 : 3, 2, 0);
    check_output("t2_stall_cnt", 32'(stall_cnt_o), 32'(exp_cnt));
    idle(3);

    // Two writers of x3: youngest wins; rs2 names x3 but is unused.
    apply_stimulus("t3_add_x3a", 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0);
    apply_stimulus("t3_add_x3b", 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0);
    apply_stimulus("t3_add_x9", 3, 1, 3, 0, 9, 1, 0, 0, FWD ? 0 : 3, 1, 0);
    check_output("t3_w_wr_en", 32'(w_wr_en_o),   FWD ? 32'd1 : 32'd0);
    check_output("t3_w_rd",    32'(w_rd_addr_o), FWD ? 32'd3 : 32'd0);
    idle(3);

    // x0 as destination is never tracked.
    apply_stimulus("t4_wr_x0", 1, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0);
    apply_stimulus("t4_rd_x0", 0, 1, 0, 1, 11, 1, 0, 0, 0, 0, 0);
    idle(1);
    check_output("t4_w_wr_en", 32'(w_wr_en_o),   32'd0);
    check_output("t4_w_rd",    32'(w_rd_addr_o), 32'd0);
    idle(3);

    // Branch kills a would-be stalled consumer.
    apply_stimulus("t5_lw_x7", 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0);
    apply_stimulus("t5_branch", 7, 1, 0, 1, 8, 1, 0, 1, 0, 0, 0);
    check_output("t5_x_valid", 32'(x_valid_o),   32'd0);
    check_output("t5_cnt",     32'(stall_cnt_o), 32'(exp_cnt));
    idle(3);

    // Drive the counter into saturation with repeated load-use pairs.
    for (int i = 0; i < 260; i++) begin
      apply_stimulus("t6_lw", 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0);
      apply_stimulus("t6_use", 7, 1, 0, 1, 8, 1, 0, 0, FWD ? 1 : 3, 2, 0);
    end
    check_output("t6_cnt_saturated", 32'(stall_cnt_o), 32'd255);

    // Asynchronous reset while a hazard is pending.
    apply_stimulus("t6_lw_pre_reset", 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0);
    d_valid_i = 1'b1; branch_taken_i = 1'b0;
    d_rs1_addr_i = 5'd7; d_rs1_used_i = 1'b1; d_rs2_addr_i = 5'd0; d_rs2_used_i = 1'b1;
    d_rd_addr_i = 5'd8; d_rd_wr_i = 1'b1; d_is_load_i = 1'b0;
    #1;
    check_output("t6_pre_reset_stall", 32'(stall_o), 32'd1);
    rst_n_i = 1'b0;
    #1;
    check_reset_state("t6_async_reset");
    d_valid_i = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Normal operation after reset, including bypass from the last stage.
    apply_stimulus("t7_add_x10", 1, 1, 2, 1, 10, 1, 0, 0, 0, 0, 0);
    idle(2);
    check_output("t7_w_wr_en", 32'(w_wr_en_o),   32'd1);
    check_output("t7_w_rd",    32'(w_rd_addr_o), 32'd10);
    apply_stimulus("t7_add_x12", 10, 1, 1, 1, 12, 1, 0, 0, FWD ? 0 : 1, 3, 0);
    check_output("t7_cnt", 32'(stall_cnt_o), 32'(exp_cnt));
    idle(3);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
